// File: rtl/imac_acc_pkg.sv
// imac_acc_pkg: shared state encoding, default widths and saturation limits for the partial-sum accumulator
package imac_acc_pkg;
  localparam int IN_W_DEF = 5;
  localparam int ACC_W_DEF = 14;
  typedef enum logic {ACC, PEND} state_e;
  function automatic longint sat_hi(int w, bit s);
    return s ? (longint'(1) << (w - 1)) - 1 : (longint'(1) << w) - 1;
  endfunction
  function automatic longint sat_lo(int w, bit s);
    return s ? -(longint'(1) << (w - 1)) : longint'(0);
  endfunction
endpackage

// File: rtl/acc_lane_sat.sv
// acc_lane_sat: one lane of extend, add and clamp with a saturation flag
module acc_lane_sat
  import imac_acc_pkg::*;
#(
  parameter int IN_W = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter bit SIGNED = 1'b0
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [IN_W-1:0]  din,
  output logic [ACC_W-1:0] sum,
  output logic             sat
);
  localparam logic [ACC_W-1:0] HI = ACC_W'(sat_hi(ACC_W, SIGNED));
  localparam logic [ACC_W-1:0] LO = ACC_W'(sat_lo(ACC_W, SIGNED));
  logic [ACC_W:0] s_x;
  // Extend both operands one bit; overflow shows as a carry (unsigned) or a sign disagreement (signed)
  always_comb begin
    s_x = {SIGNED & acc[ACC_W-1], acc} + {{(ACC_W + 1 - IN_W){SIGNED & din[IN_W-1]}}, din};
    sat = SIGNED ? s_x[ACC_W] ^ s_x[ACC_W-1] : s_x[ACC_W];
    sum = !sat ? s_x[ACC_W-1:0] : (SIGNED && s_x[ACC_W]) ? LO : HI;
  end
endmodule

// File: rtl/psum_accumulator.sv
// psum_accumulator: NCH-lane saturating frame accumulator with valid/ready on both sides
module psum_accumulator
  import imac_acc_pkg::*;
#(
  parameter int IN_W = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int NCH = 4,
  parameter int LEN_W = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCH*IN_W-1:0]  in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*ACC_W-1:0] out_data,
  output logic [NCH-1:0]       out_sat,
  output logic [LEN_W-1:0]     out_count
);
  state_e state_q, state_d;
  logic [NCH*ACC_W-1:0] acc_q, acc_d, sum, od_q, od_d;
  logic [NCH-1:0] sat_q, sat_d, lsat, os_q, os_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, oc_q, oc_d, cnt_inc;
  logic accept;
  for (genvar k = 0; k < NCH; k++) begin : g_lane
    acc_lane_sat #(.IN_W(IN_W), .ACC_W(ACC_W), .SIGNED(SIGNED)) u_lane (
      .acc(acc_q[k*ACC_W +: ACC_W]),
      .din(in_data[k*IN_W +: IN_W]),
      .sum(sum[k*ACC_W +: ACC_W]),
      .sat(lsat[k])
    );
  end
  assign out_valid = state_q == PEND;
  assign in_ready = !clr && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
  assign out_data = od_q;
  assign out_sat = os_q;
  assign out_count = oc_q;
  // Next state: clr and a last beat wipe the running frame; a last beat also loads the output register
  always_comb begin
    acc_d = clr ? '0 : acc_q;
    sat_d = clr ? '0 : sat_q;
    cnt_d = clr ? '0 : cnt_q;
    od_d = od_q;
    os_d = os_q;
    oc_d = oc_q;
    state_d = (out_valid && out_ready) ? ACC : state_q;
    if (accept) begin
      acc_d = in_last ? '0 : sum;
      sat_d = in_last ? '0 : sat_q | lsat;
      cnt_d = in_last ? '0 : cnt_inc;
      od_d = in_last ? sum : od_q;
      os_d = in_last ? sat_q | lsat : os_q;
      oc_d = in_last ? cnt_inc : oc_q;
      state_d = in_last ? PEND : state_d;
    end
  end
  // State, accumulator and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ACC;
      acc_q <= '0;
      sat_q <= '0;
      cnt_q <= '0;
      od_q <= '0;
      os_q <= '0;
      oc_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      sat_q <= sat_d;
      cnt_q <= cnt_d;
      od_q <= od_d;
      os_q <= os_d;
      oc_q <= oc_d;
    end
  end
endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: directed checks of an unsigned and a signed accumulator driven in lockstep
module tb_psum_accumulator;
  logic clk = 1'b0;
  logic reset_n, clr, in_valid, in_last, out_ready;
  logic [19:0] in_data;
  logic u_in_ready, u_out_valid, s_in_ready, s_out_valid;
  logic [55:0] u_out_data, s_out_data;
  logic [3:0] u_out_sat, s_out_sat;
  logic [7:0] u_out_count, s_out_count;
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  psum_accumulator u (
    .clk(clk), .reset_n(reset_n), .clr(clr), .in_valid(in_valid), .in_ready(u_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(u_out_valid), .out_ready(out_ready),
    .out_data(u_out_data), .out_sat(u_out_sat), .out_count(u_out_count)
  );
  psum_accumulator #(.SIGNED(1'b1)) s (
    .clk(clk), .reset_n(reset_n), .clr(clr), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_sat(s_out_sat), .out_count(s_out_count)
  );

  function automatic logic [19:0] pk(logic [4:0] a0, logic [4:0] a1, logic [4:0] a2, logic [4:0] a3);
    return {a3, a2, a1, a0};
  endfunction
  function automatic logic [55:0] po(logic [13:0] a0, logic [13:0] a1, logic [13:0] a2, logic [13:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic [19:0] d, input logic last);
    in_valid = 1'b1;
    in_data = d;
    in_last = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1; in_data = '0;
    #3;
    chk("rst_valid", 64'(u_out_valid), 64'd0);
    chk("rst_data", 64'(u_out_data), 64'd0);
    chk("rst_count", 64'(u_out_count), 64'd0);
    chk("rst_sat", 64'(u_out_sat), 64'd0);
    chk("rst_ready", 64'(u_in_ready), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    // Three-beat unsigned frame
    send(pk(1, 2, 3, 31), 1'b0);
    send(pk(1, 2, 3, 31), 1'b0);
    chk("a_no_early_valid", 64'(u_out_valid), 64'd0);
    send(pk(1, 2, 3, 31), 1'b1);
    chk("a_valid", 64'(u_out_valid), 64'd1);
    chk("a_data", 64'(u_out_data), 64'(po(3, 6, 9, 93)));
    chk("a_count", 64'(u_out_count), 64'd3);
    chk("a_sat", 64'(u_out_sat), 64'd0);
    chk("a_signed_data", 64'(s_out_data), 64'(po(3, 6, 9, 14'h3FFD)));
    @(posedge clk);
    #1;
    chk("a_valid_drop", 64'(u_out_valid), 64'd0);
    chk("a_data_hold", 64'(u_out_data), 64'(po(3, 6, 9, 93)));
    // 600 beats of 31 on lane 0: unsigned clamps, signed sees -1 per beat
    for (int i = 0; i < 599; i++) send(pk(31, 0, 0, 0), 1'b0);
    send(pk(31, 0, 0, 0), 1'b1);
    chk("usat_data", 64'(u_out_data), 64'(po(16383, 0, 0, 0)));
    chk("usat_flag", 64'(u_out_sat), 64'd1);
    chk("usat_count", 64'(u_out_count), 64'd255);
    chk("usat_signed_data", 64'(s_out_data), 64'(po(14'h3DA8, 0, 0, 0)));
    chk("usat_signed_flag", 64'(s_out_sat), 64'd0);
    // Signed frame: -16 x3 then +5
    for (int i = 0; i < 3; i++) send(pk(5'b10000, 0, 0, 0), 1'b0);
    send(pk(5, 0, 0, 0), 1'b1);
    chk("s_data", 64'(s_out_data), 64'(po(14'h3FD5, 0, 0, 0)));
    chk("s_count", 64'(s_out_count), 64'd4);
    chk("s_unsigned_data", 64'(u_out_data), 64'(po(53, 0, 0, 0)));
    // 600 beats of -16: signed clamps low
    for (int i = 0; i < 599; i++) send(pk(5'b10000, 0, 0, 0), 1'b0);
    send(pk(5'b10000, 0, 0, 0), 1'b1);
    chk("ssat_data", 64'(s_out_data), 64'(po(14'h2000, 0, 0, 0)));
    chk("ssat_flag", 64'(s_out_sat), 64'd1);
    chk("ssat_count", 64'(s_out_count), 64'd255);
    chk("ssat_unsigned_data", 64'(u_out_data), 64'(po(9600, 0, 0, 0)));
    chk("ssat_unsigned_flag", 64'(u_out_sat), 64'd0);
    // Backpressure with a second frame waiting
    send(pk(1, 0, 0, 0), 1'b1);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = pk(2, 0, 0, 0); in_last = 1'b1;
    #1;
    chk("bp_ready_low", 64'(u_in_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_ready", 64'(u_in_ready), 64'd0);
      chk("bp_valid", 64'(u_out_valid), 64'd1);
      chk("bp_data", 64'(u_out_data), 64'(po(1, 0, 0, 0)));
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(u_in_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("b2b_1_valid", 64'(u_out_valid), 64'd1);
    chk("b2b_1_data", 64'(u_out_data), 64'(po(2, 0, 0, 0)));
    in_data = pk(3, 0, 0, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    chk("b2b_2_valid", 64'(u_out_valid), 64'd1);
    chk("b2b_2_data", 64'(u_out_data), 64'(po(3, 0, 0, 0)));
    chk("b2b_2_count", 64'(u_out_count), 64'd1);
    @(posedge clk);
    #1;
    chk("b2b_drop", 64'(u_out_valid), 64'd0);
    // clr mid-frame discards the partial sum
    send(pk(7, 0, 0, 0), 1'b0);
    send(pk(7, 0, 0, 0), 1'b0);
    clr = 1'b1;
    #1;
    chk("clr_ready", 64'(u_in_ready), 64'd0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    send(pk(4, 0, 0, 0), 1'b1);
    chk("clr_data", 64'(u_out_data), 64'(po(4, 0, 0, 0)));
    chk("clr_count", 64'(u_out_count), 64'd1);
    // clr while a result is pending leaves it intact
    send(pk(5, 0, 0, 0), 1'b1);
    clr = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("clr_pend_valid", 64'(u_out_valid), 64'd1);
    chk("clr_pend_data", 64'(u_out_data), 64'(po(5, 0, 0, 0)));
    clr = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_pend_done", 64'(u_out_valid), 64'd0);
    // Asynchronous reset mid-frame
    send(pk(9, 9, 9, 9), 1'b0);
    send(pk(9, 9, 9, 9), 1'b0);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_data", 64'(u_out_data), 64'd0);
    chk("arst_valid", 64'(u_out_valid), 64'd0);
    chk("arst_count", 64'(u_out_count), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    send(pk(9, 0, 0, 0), 1'b1);
    chk("post_rst_data", 64'(u_out_data), 64'(po(9, 0, 0, 0)));
    chk("post_rst_count", 64'(u_out_count), 64'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
Multi-channel partial-sum accumulator; parametrised successor of the single-channel 5-bit/14-bit accumulator. Accumulates NCH parallel lanes over a frame of input beats delimited by in_last. Adds signed/unsigned mode, saturation, a beat counter and valid/ready handshakes on both sides. Sits between the IMAC column ADC/readout stage and downstream activation/writeback logic.

Parameters:
IN_W, 5, width of each input lane
ACC_W, 14, width of each accumulator lane (ACC_W > IN_W)
NCH, 4, number of parallel channels
LEN_W, 8, width of beat counter
SIGNED, 0, 0 = unsigned lanes, 1 = two's-complement lanes

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
clr  in  1  synchronous clear of accumulators and beat count
in_valid  in  1  input beat valid
in_ready  out  1  block accepts input beat
in_data  in  NCH*IN_W  lane k at [k*IN_W +: IN_W]
in_last  in  1  qualifies final beat of frame
out_valid  out  1  frame result valid
out_ready  in  1  downstream accepts result
out_data  out  NCH*ACC_W  lane k at [k*ACC_W +: ACC_W]
out_sat  out  NCH  per-lane sticky saturation flag for the frame
out_count  out  LEN_W  beats in the frame, including last

Behaviour:
- Reset (reset_n=0, async): accumulators=0, count=0, per-lane sat=0, out_data=0, out_sat=0, out_count=0, out_valid=0, state=ACC.
- in_ready = !clr && (!out_valid || out_ready). Combinational; no dependence on in_valid.
- Accept = in_valid && in_ready.
- Lane add: input sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to ACC_W+1 bits; sum computed at ACC_W+1 bits and clamped.
- Unsigned clamp: 2^ACC_W-1. Signed clamp: +(2^(ACC_W-1)-1) / -(2^(ACC_W-1)).
- Clamping sets that lane's sticky sat bit. A saturated lane keeps accumulating from the clamped value.
- Count increments per accepted beat and saturates at 2^LEN_W-1.
- State ACC (out_valid=0) or PEND (out_valid=1).
- Accept, in_last=0: accumulators/sat/count update; state unchanged.
- Accept, in_last=1: next cycle out_data = accumulators+in_data (clamped); out_sat = sat including this beat; out_count = count+1 (saturated). Accumulators, count and sat cleared the same edge; state -> PEND.
- Latency: result visible on out_data the cycle after the last beat is accepted.
- PEND, out_ready=1, no accept: out_valid -> 0, state -> ACC. out_data holds its value.
- PEND, out_ready=1, accept with in_last=1: new result overwrites output; out_valid stays 1 (back-to-back frames, no bubble).
- PEND, out_ready=1, accept with in_last=0: accumulate; out_valid -> 0.
- PEND, out_ready=0: in_ready=0; out_data/out_sat/out_count stable, out_valid held (AXI-style: must not drop).
- clr=1: accumulators, count, sat cleared next edge. in_ready=0, so no beat is lost silently. Output register and out_valid are unaffected; clr does not cancel a pending result.
- in_valid with in_last on the very first beat: 1-beat frame, out_count=1.
- Mid-frame reset: partial sums discarded, no output produced.
- No combinational path from in_data to out_data. in_ready depends only on clr, out_valid, out_ready.

Decomposition:
- Shared package (imac_acc_pkg): state enum {ACC, PEND}; function computing signed/unsigned saturation limits from ACC_W; default width constants IN_W/ACC_W.
- One sub-module: acc_lane_sat (single lane: extend, add, clamp, sat flag, SIGNED param), instantiated NCH times by generate.
- FSM, counter and output register live in the top.

Test Plan:
- Unsigned, NCH=4: frame of 3 beats, lanes {1,2,3,31} each beat, out_ready=1 -> out_data lanes {3,6,9,93}, out_count=3, out_sat=0, out_valid high for 1 cycle.
- Unsigned saturation: 600 beats of 31 on lane 0 -> lane 0 clamps at 16383, out_sat[0]=1, out_count=255 (LEN_W=8 saturation).
- SIGNED=1: beats of -16 (5'b10000) x 3 then +5, last -> lane = -43. Drive -16 x 600 -> clamp -8192, sat set.
- Backpressure: out_ready=0 for 5 cycles with second frame pending -> in_ready=0, out_data stable. Release -> second frame accepted, and back-to-back last beats produce results on consecutive cycles with no out_valid gap.
- clr mid-frame after 2 beats of 7, then 1 beat of 4 with last -> result 4, count=1. clr while PEND -> pending result still delivered unchanged.
- Assert reset_n low mid-frame (asynchronously, between edges) -> all outputs 0 immediately. After release, a 1-beat frame of {9} -> out_data lane 0=9, out_count=1.
